// File: rtl/alu_operand_stage.sv
// Operand-fetch / writeback stage in front of an 8-bit ALU.
// It reads a small register file, bypasses from EX, and registers the ALU
// operands. It writes the ALU result and flags back one edge later.
// r0 is hard-wired to zero. A global hold freezes all of the stage's state.
module alu_operand_stage #(
  parameter int NREGS  = 4,
  parameter int DATA_W = 8,
  localparam int AW    = (NREGS > 1) ? $clog2(NREGS) : 1
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     in_rd,
  input  logic [AW-1:0]     in_rs1,
  input  logic [AW-1:0]     in_rs2,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_op,
  output logic [DATA_W-1:0] operand1,
  output logic [DATA_W-1:0] operand2,
  output logic              sigALUOp,
  output logic              ex_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [1:0]        alu_flags,
  output logic [1:0]        flags_q,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [NREGS-1:0][DATA_W-1:0] rf;
  logic [AW-1:0]                ex_rd;
  logic                         xfer;
  logic                         wb;
  logic [DATA_W-1:0]            src1;
  logic [DATA_W-1:0]            src2;

  assign in_ready = !reset && !hold;
  assign xfer     = in_valid && in_ready;
  // A stalled writeback simply waits; it lands on the first edge after hold drops.
  assign wb       = ex_valid && !hold;

  // Source read: r0 is zero, the in-flight EX result wins over the regfile.
  function automatic logic [DATA_W-1:0] src_sel(
    input logic [AW-1:0]                rs,
    input logic                         wb_i,
    input logic [AW-1:0]                wrd,
    input logic [DATA_W-1:0]            res,
    input logic [NREGS-1:0][DATA_W-1:0] regs
  );
    if (rs == '0)                 return '0;
    else if (wb_i && (wrd == rs)) return res;
    else                          return regs[rs];
  endfunction

  // Operand mux for both ALU inputs, including immediate select on operand2.
  always_comb begin
    src1 = src_sel(in_rs1, wb, ex_rd, alu_result, rf);
    src2 = in_use_imm ? in_imm : src_sel(in_rs2, wb, ex_rd, alu_result, rf);
  end

  // Register file and flags writeback; r0 is never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf      <= '0;
      flags_q <= '0;
    end else if (wb) begin
      if (ex_rd != '0) rf[ex_rd] <= alu_result;
      flags_q <= alu_flags;
    end
  end

  // Operand pipeline register; on a bubble only ex_valid drops so the ALU inputs stay stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      operand1 <= '0;
      operand2 <= '0;
      sigALUOp <= 1'b0;
      ex_rd    <= '0;
      ex_valid <= 1'b0;
    end else if (!hold) begin
      ex_valid <= xfer;
      if (xfer) begin
        ex_rd    <= in_rd;
        sigALUOp <= in_op;
        operand1 <= src1;
        operand2 <= src2;
      end
    end
  end

  // Debug read port, architectural view only (no bypass).
  always_comb begin
    dbg_data = (dbg_addr == '0) ? '0 : rf[dbg_addr];
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage. It uses a behavioural 8-bit ALU
// (op 0 = add, op 1 = sub, flag bit1 = signed overflow). A table of
// back-to-back instructions is followed by hand-written hold and reset sequences.
module tb_alu_operand_stage;

  logic       clk = 1'b0;
  logic       reset, hold, in_valid, in_ready;
  logic [1:0] in_rd, in_rs1, in_rs2, dbg_addr;
  logic       in_use_imm, in_op, sigALUOp, ex_valid;
  logic [7:0] in_imm, operand1, operand2, alu_result, dbg_data;
  logic [1:0] alu_flags, flags_q;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .reset(reset), .hold(hold),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_use_imm(in_use_imm), .in_imm(in_imm), .in_op(in_op),
    .operand1(operand1), .operand2(operand2), .sigALUOp(sigALUOp),
    .ex_valid(ex_valid), .alu_result(alu_result), .alu_flags(alu_flags),
    .flags_q(flags_q), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Behavioural ALU: add/sub with signed overflow in flag bit 1.
  logic [7:0] b_eff;
  logic       ovf;
  always_comb begin
    b_eff      = sigALUOp ? ~operand2 : operand2;
    alu_result = operand1 + b_eff + {7'd0, sigALUOp};
    ovf        = (operand1[7] == b_eff[7]) && (alu_result[7] != operand1[7]);
    alu_flags  = {ovf, 1'b0};
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic ui, input logic [7:0] imm,
                       input logic op);
    in_valid = v; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_use_imm = ui; in_imm = imm; in_op = op;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0] rd, rs1, rs2;
    logic       ui;
    logic [7:0] imm;
    logic       op;
    logic [7:0] e_op1, e_op2;
    logic [7:0] e_res;
    logic [1:0] e_flg;
  } vec_t;

  vec_t vt[10];

  initial begin
    // rd rs1 rs2 ui imm op | op1 op2 | R[rd] flags
    vt[0] = '{2'd1, 2'd0, 2'd0, 1'b1, 8'h05, 1'b0, 8'h00, 8'h05, 8'h05, 2'b00};
    vt[1] = '{2'd2, 2'd0, 2'd0, 1'b1, 8'h03, 1'b0, 8'h00, 8'h03, 8'h03, 2'b00};
    vt[2] = '{2'd3, 2'd1, 2'd2, 1'b0, 8'h00, 1'b0, 8'h05, 8'h03, 8'h08, 2'b00}; // r2 via bypass
    vt[3] = '{2'd1, 2'd0, 2'd0, 1'b1, 8'h70, 1'b0, 8'h00, 8'h70, 8'h70, 2'b00};
    vt[4] = '{2'd2, 2'd0, 2'd0, 1'b1, 8'h70, 1'b0, 8'h00, 8'h70, 8'h70, 2'b00};
    vt[5] = '{2'd3, 2'd1, 2'd2, 1'b0, 8'h00, 1'b0, 8'h70, 8'h70, 8'hE0, 2'b10}; // overflow
    vt[6] = '{2'd0, 2'd0, 2'd0, 1'b1, 8'h55, 1'b0, 8'h00, 8'h55, 8'h00, 2'b00}; // r0 write, flags clear
    vt[7] = '{2'd1, 2'd0, 2'd0, 1'b1, 8'h01, 1'b0, 8'h00, 8'h01, 8'h01, 2'b00}; // rs1=0, no bypass of r0
    vt[8] = '{2'd2, 2'd3, 2'd1, 1'b0, 8'h00, 1'b1, 8'hE0, 8'h01, 8'hDF, 2'b00}; // sub, r1 via bypass
    vt[9] = '{2'd1, 2'd2, 2'd0, 1'b1, 8'h60, 1'b1, 8'hDF, 8'h60, 8'h7F, 2'b10}; // sub overflow

    // Reset with hold and a valid instruction pending.
    reset = 1'b1; hold = 1'b1; dbg_addr = 2'd0;
    drive(1'b1, 2'd1, 2'd0, 2'd0, 1'b1, 8'hAA, 1'b1);
    #1;
    chk("rst_in_ready", {15'd0, in_ready}, 16'd0);
    tick();
    chk("rst_ex_valid", {15'd0, ex_valid}, 16'd0);
    chk("rst_flags", {14'd0, flags_q}, 16'd0);
    chk("rst_operands", {operand1, operand2}, 16'h0000);
    chk("rst_op", {15'd0, sigALUOp}, 16'd0);
    for (int a = 0; a < 4; a++) begin
      dbg_addr = 2'(a);
      #1;
      chk("rst_dbg", {8'd0, dbg_data}, 16'd0);
    end
    reset = 1'b0; hold = 1'b0;
    drive(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 1'b0);
    tick();

    // Back-to-back table: operands one edge after acceptance, result one edge later.
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) drive(1'b1, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].ui, vt[i].imm, vt[i].op);
      else        drive(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 1'b0);
      if (i > 0) dbg_addr = vt[i-1].rd;
      tick();
      if (i < 10) begin
        chk("tbl_op1", {8'd0, operand1}, {8'd0, vt[i].e_op1});
        chk("tbl_op2", {8'd0, operand2}, {8'd0, vt[i].e_op2});
        chk("tbl_aluop", {15'd0, sigALUOp}, {15'd0, vt[i].op});
        chk("tbl_ex_valid", {15'd0, ex_valid}, 16'd1);
      end else begin
        chk("tbl_drain_valid", {15'd0, ex_valid}, 16'd0);
      end
      if (i > 0) begin
        chk("tbl_wb_data", {8'd0, dbg_data}, {8'd0, vt[i-1].e_res});
        chk("tbl_flags", {14'd0, flags_q}, {14'd0, vt[i-1].e_flg});
      end
    end

    // Hold mid-flight: r1 (0x7F) must stay put until hold drops.
    drive(1'b1, 2'd1, 2'd0, 2'd0, 1'b1, 8'h2A, 1'b0);
    dbg_addr = 2'd1;
    tick();
    chk("hold_accept_op2", {8'd0, operand2}, 16'h002A);
    hold = 1'b1;
    drive(1'b1, 2'd2, 2'd0, 2'd0, 1'b1, 8'h99, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("hold_in_ready", {15'd0, in_ready}, 16'd0);
      tick();
      chk("hold_r1_frozen", {8'd0, dbg_data}, 16'h007F);
      chk("hold_ops_frozen", {operand1, operand2}, 16'h002A);
      chk("hold_ex_valid", {15'd0, ex_valid}, 16'd1);
      chk("hold_flags", {14'd0, flags_q}, 16'b10);
    end
    hold = 1'b0;
    drive(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 1'b0);
    tick();
    chk("hold_release_r1", {8'd0, dbg_data}, 16'h002A);
    chk("hold_release_flags", {14'd0, flags_q}, 16'd0);
    chk("hold_no_accept", {15'd0, ex_valid}, 16'd0);
    chk("hold_op2_kept", {8'd0, operand2}, 16'h002A);

    // Reset while r2 = r0 + 0x11 is in EX: the writeback is discarded.
    drive(1'b1, 2'd2, 2'd0, 2'd0, 1'b1, 8'h11, 1'b0);
    tick();
    reset = 1'b1;
    drive(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 1'b0);
    tick();
    reset = 1'b0;
    dbg_addr = 2'd2;
    #1;
    chk("mrst_r2", {8'd0, dbg_data}, 16'd0);
    chk("mrst_ex_valid", {15'd0, ex_valid}, 16'd0);
    chk("mrst_flags", {14'd0, flags_q}, 16'd0);
    dbg_addr = 2'd1;
    #1;
    chk("mrst_r1", {8'd0, dbg_data}, 16'd0);

    // Normal operation resumes after reset.
    drive(1'b1, 2'd3, 2'd0, 2'd0, 1'b1, 8'h22, 1'b0);
    tick();
    chk("post_op2", {8'd0, operand2}, 16'h0022);
    drive(1'b1, 2'd2, 2'd3, 2'd0, 1'b1, 8'h01, 1'b0);
    dbg_addr = 2'd3;
    tick();
    chk("post_r3", {8'd0, dbg_data}, 16'h0022);
    chk("post_bypass_op1", {8'd0, operand1}, 16'h0022);
    drive(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 1'b0);
    dbg_addr = 2'd2;
    tick();
    chk("post_r2", {8'd0, dbg_data}, 16'h0023);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
Operand-fetch/writeback stage directly upstream of the ALU. Accepts one decoded ALU instruction per cycle and reads a small register file. Drives the ALU's operand1/operand2/sigALUOp from a pipeline register, then writes the ALU's combinational result and flags back on the following clock edge. Includes an EX-to-operand bypass and a global hold.

Parameters:
NREGS, 4, number of 8-bit architectural registers; address width is clog2(NREGS), 2 at default.
DATA_W, 8, datapath width; must match the ALU (8).

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
hold  input  1  global stall from controller; freezes the stage.
in_valid  input  1  decoded instruction present.
in_ready  output  1  stage accepts an instruction this cycle.
in_rd  input  2  destination register.
in_rs1  input  2  source register for operand1.
in_rs2  input  2  source register for operand2.
in_use_imm  input  1  1: operand2 = in_imm; 0: operand2 = R[in_rs2].
in_imm  input  8  immediate.
in_op  input  1  ALU op select, passed to sigALUOp.
operand1  output  8  registered ALU operand 1.
operand2  output  8  registered ALU operand 2.
sigALUOp  output  1  registered ALU op select.
ex_valid  output  1  operand register holds a live instruction.
alu_result  input  8  ALU result (combinational from operand1/operand2).
alu_flags  input  2  ALU flags; bit1 = overflow, bit0 = reserved 0.
flags_q  output  2  architectural flag register.
dbg_addr  input  2  debug register read address.
dbg_data  output  8  combinational R[dbg_addr]; r0 always reads 0.

Behaviour:
- in_ready = !reset && !hold (combinational).
- Transfer occurs when in_valid && in_ready.
- Reset (synchronous, at the clock edge with reset=1):
  - All registers R[0..NREGS-1] = 0; operand1 = operand2 = 0; sigALUOp = 0; ex_valid = 0; ex_rd = 0; flags_q = 0.
  - Reset overrides hold and any transfer. A pending writeback in that cycle is discarded.
- r0 is hard-wired to zero: reads return 0 and writes are ignored. Flags are still updated by instructions with rd = 0.
- Writeback condition: wb = ex_valid && !hold.
  - On wb: R[ex_rd] <= alu_result (if ex_rd != 0) and flags_q <= alu_flags.
- Operand load, on each edge with !hold and !reset:
  - ex_valid <= transfer.
  - If transfer: ex_rd <= in_rd; sigALUOp <= in_op; operand1 <= src(in_rs1); operand2 <= in_use_imm ? in_imm : src(in_rs2).
  - If no transfer: operand1, operand2, sigALUOp and ex_rd hold their values; only ex_valid drops.
- Source read src(rs):
  - 0 if rs == 0.
  - Otherwise alu_result if wb && ex_rd == rs (bypass).
  - Otherwise R[rs].
  - Back-to-back dependent instructions therefore never see stale data.
- hold = 1: no register changes at all (operands, ex_valid, regfile, flags). The ALU output stays stable. The writeback completes on the first edge with hold = 0.
- Latency:
  - An accepted instruction appears at the ALU inputs 1 cycle after acceptance.
  - Its result is architecturally visible (dbg_data, flags_q) 2 cycles after acceptance, absent hold.
  - Throughput is 1 instruction per cycle.
- Arithmetic is performed entirely in the ALU; this block does no width extension. All values are 8-bit, and the result wraps as produced by the ALU.
- No state machine beyond the ex_valid pipeline bit. Any implementation of 120–400 lines must include the bypass mux and the r0 rule.

Test Plan:
1. Reset with hold = 1 and in_valid = 1 -> after one edge: ex_valid = 0, flags_q = 00, operand1 = operand2 = 00, in_ready = 0 while reset is high, dbg_data = 00 for all addresses.
2. Back-to-back bypass: r1 = r0 + imm 0x05, r2 = r0 + imm 0x03, r3 = r1 + r2 on consecutive cycles -> third instruction sees operand1 = 0x05, operand2 = 0x03 (r2 via bypass); r3 = 0x08 two cycles later; flags_q = 00.
3. Overflow: r1 = 0x70 and r2 = 0x70 via immediates, then r3 = r1 + r2 -> r3 = 0xE0, flags_q = 2'b10. A following r0 + imm 0x01 -> flags_q = 00.
4. Hold mid-flight: accept r1 = r0 + 0x2A, assert hold for 3 cycles -> in_ready = 0, R[1] stays 00 and operands stay frozen during hold; R[1] = 0x2A on the first edge after hold drops.
5. r0 write: rd = 0, imm 0x55 -> dbg r0 = 00; next instruction rs1 = 0 gets operand1 = 00 (no bypass); flags_q updated to 00.
6. Reset mid-operation: accept r2 = r0 + 0x11, assert reset on the following cycle -> R[2] = 00, ex_valid = 0, flags_q = 00; subsequent instructions execute normally.
